// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman datapath: widths, FSM states,
// and the reduction destination selects.
package dh_pkg;
    localparam int P_W_DEF    = 32;
    localparam int E_W_DEF    = 32;
    localparam int OUT_W_DEF  = 64;
    localparam int RED_CYCLES = 64;

    localparam logic DEST_ACC = 1'b0;
    localparam logic DEST_B   = 1'b1;

    typedef enum logic [2:0] {
        IDLE, LOAD, RED, TEST, MUL, SQR, DONE, DONE_HOLD
    } state_t;
endpackage

// File: rtl/mod_reduce_serial.sv
// Bit-serial shift-subtract reducer: one product bit per cycle, MSB first.
// o_done/o_rem are combinational so the caller captures on the final edge.
module mod_reduce_serial
    import dh_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int VAL_W = RED_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [VAL_W-1:0] i_val,
    input  logic [P_W-1:0]   i_p,
    output logic             o_done,
    output logic [P_W-1:0]   o_rem
);
    localparam int CNT_W = $clog2(VAL_W);

    logic [P_W-1:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_act;
    logic [P_W:0]     w_shift;
    logic [P_W:0]     w_diff;

    // rem < p is invariant, so the shifted value is < 2p and the sign of
    // (shift - p) alone decides whether to subtract.
    assign w_shift = {r_rem, i_val[CNT_W'(VAL_W - 1) - r_cnt]};
    assign w_diff  = w_shift - {1'b0, i_p};
    assign o_rem   = w_diff[P_W] ? w_shift[P_W-1:0] : w_diff[P_W-1:0];
    assign o_done  = r_act && (r_cnt == CNT_W'(VAL_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_cnt <= '0;
            r_act <= 1'b1;
        end else if (r_act) begin
            r_rem <= o_rem;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) r_act <= 1'b0;
        end
    end
endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation, base^e mod p,
// with every product reduced by the serial reducer (no divider).
module mod_exp_engine
    import dh_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int E_W   = E_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [P_W-1:0]   base,
    input  logic [E_W-1:0]   e,
    input  logic [P_W-1:0]   p,
    output logic [OUT_W-1:0] exp,
    output logic             st,
    output logic             busy,
    output logic             err
);
    localparam int PR_W = 2 * P_W;

    state_t          r_state, w_state_nxt;
    logic [P_W-1:0]  r_base, r_p, r_acc, r_b;
    logic [E_W-1:0]  r_e;
    logic [PR_W-1:0] r_prod;
    logic            r_dest, r_from_sqr;
    logic            w_red_start, w_red_done;
    logic [P_W-1:0]  w_rem;

    mod_reduce_serial #(.P_W(P_W), .VAL_W(PR_W)) u_red (
        .clk    (clk),
        .rst    (rst),
        .i_start(w_red_start),
        .i_val  (r_prod),
        .i_p    (r_p),
        .o_done (w_red_done),
        .o_rem  (w_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_red_start = 1'b0;
        unique case (r_state)
            IDLE, DONE_HOLD: if (start) w_state_nxt = (p == '0) ? DONE : LOAD;
            LOAD, MUL, SQR: begin
                w_red_start = 1'b1;
                w_state_nxt = RED;
            end
            RED:  if (w_red_done) w_state_nxt = (r_dest == DEST_ACC) ? SQR : TEST;
            TEST: w_state_nxt = (r_e == '0) ? DONE : (r_e[0] ? MUL : SQR);
            DONE: w_state_nxt = DONE_HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base     <= '0;
            r_p        <= '0;
            r_e        <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_prod     <= '0;
            r_dest     <= DEST_B;
            r_from_sqr <= 1'b0;
            exp        <= '0;
            st         <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE_HOLD: if (start) begin
                    r_base <= base;
                    r_e    <= e;
                    r_p    <= p;
                    r_acc  <= '0;
                    st     <= 1'b0;
                    err    <= 1'b0;
                    busy   <= 1'b1;
                end
                LOAD: begin
                    r_prod     <= PR_W'(r_base);
                    r_dest     <= DEST_B;
                    r_from_sqr <= 1'b0;
                    r_acc      <= (r_p == P_W'(1)) ? '0 : P_W'(1);
                end
                RED: if (w_red_done) begin
                    if (r_dest == DEST_ACC) begin
                        r_acc <= w_rem;
                    end else begin
                        r_b <= w_rem;
                        // the exponent bit is consumed once b has been squared
                        if (r_from_sqr) r_e <= r_e >> 1;
                    end
                end
                MUL: begin
                    r_prod <= PR_W'(r_acc) * PR_W'(r_b);
                    r_dest <= DEST_ACC;
                end
                SQR: begin
                    r_prod     <= PR_W'(r_b) * PR_W'(r_b);
                    r_dest     <= DEST_B;
                    r_from_sqr <= 1'b1;
                end
                DONE: begin
                    exp  <= OUT_W'(r_acc);
                    st   <= 1'b1;
                    busy <= 1'b0;
                    err  <= (r_p == '0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed and randomized checks of mod_exp_engine against a plain-arithmetic
// modular exponent and a closed-form latency model.
module tb_mod_exp_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] e = '0;
    logic [31:0] p = '0;
    logic [63:0] exp;
    logic        st, busy, err;

    int n_vec = 0;
    int n_err = 0;

    mod_exp_engine dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .base (base),
        .e    (e),
        .p    (p),
        .exp  (exp),
        .st   (st),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] model_exp(input logic [31:0] b, input logic [31:0] ee,
                                              input logic [31:0] pp);
        longint unsigned r, x, m;
        if (pp == 0) return 64'd0;
        m = 64'(pp);
        r = 64'd1 % m;
        x = 64'(b) % m;
        for (int i = 0; i < 32; i++) begin
            if (ee[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r;
    endfunction

    // accept edge -> DONE edge for p==0; otherwise one LOAD+reduce, a test
    // per exponent bit plus a square and optional multiply, then final test+DONE
    function automatic int model_lat(input logic [31:0] ee, input logic [31:0] pp);
        int n, k;
        if (pp == 0) return 1;
        n = 0;
        k = 0;
        for (int i = 0; i < 32; i++) if (ee[i]) begin
            n = i + 1;
            k++;
        end
        return 67 + 66 * n + 65 * k;
    endfunction

    task automatic run_op(input string nm, input logic [31:0] b, input logic [31:0] ee,
                          input logic [31:0] pp, input int spam);
        logic [63:0] want;
        int          want_lat, cyc;
        want     = model_exp(b, ee, pp);
        want_lat = model_lat(ee, pp);
        @(negedge clk);
        base  = b;
        e     = ee;
        p     = pp;
        start = 1'b1;
        @(posedge clk); #1;
        chk({nm, ".busy_acc"}, 64'(busy), 64'd1);
        chk({nm, ".st_drop"}, 64'(st), 64'd0);
        cyc = 0;
        while (!st && cyc < want_lat + 50) begin
            @(negedge clk);
            if (cyc < spam) begin
                start = 1'b1;
                base  = $urandom;
                e     = $urandom;
                p     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({nm, ".latency"}, 64'(cyc), 64'(want_lat));
        chk({nm, ".exp"}, exp, want);
        chk({nm, ".err"}, 64'(err), 64'(pp == 0));
        chk({nm, ".busy_done"}, 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, ".hold"}, {63'd0, st} ^ exp, 64'd1 ^ want);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.exp", exp, 64'd0);
        chk("rst.st", 64'(st), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        @(negedge clk) rst = 1'b1;

        run_op("t3_5_7", 32'd3, 32'd5, 32'd7, 0);
        run_op("t2_10_1000", 32'd2, 32'd10, 32'd1000, 0);
        run_op("e0", 32'd12345, 32'd0, 32'd7, 0);
        run_op("fermat", 32'd2, 32'd4294967290, 32'd4294967291, 0);
        run_op("sq_m1", 32'd4294967290, 32'd2, 32'd4294967291, 0);
        run_op("p1", $urandom, 32'h0000_1234, 32'd1, 0);
        run_op("p0", $urandom, $urandom, 32'd0, 0);
        run_op("spam", 32'd3, 32'd5, 32'd7, 100);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] rb, re, rp;
            rb = $urandom;
            re = $urandom & 32'h0000_FFFF;
            rp = (i % 3 == 0) ? 32'($urandom_range(2, 300)) : $urandom;
            if (rp == 0) rp = 32'd1;
            run_op($sformatf("rnd%0d", i), rb, re, rp, 0);
        end

        // abort mid-reduction, then confirm a clean fresh result
        @(negedge clk);
        base  = 32'd3;
        e     = 32'd5;
        p     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst.exp", exp, 64'd0);
        chk("arst.st", 64'(st), 64'd0);
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.err", 64'(err), 64'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        run_op("post_rst", 32'd5, 32'd3, 32'd11, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
